// File: rtl/uart_tx_mmio_if.sv
// Memory-side bus bundle for the UART transmitter window.
//   PADDR    : physical address from the memory controller
//   PWRITE   : one-cycle write strobe
//   PDATA    : write data
//   PRDATA   : combinational read data (0 outside the window)
//   PSEL_HIT : combinational window hit
// master = memory controller side, slave = UART side.
interface uart_tx_mmio_if;
  logic [63:0] PADDR;
  logic        PWRITE;
  logic [63:0] PDATA;
  logic [63:0] PRDATA;
  logic        PSEL_HIT;

  modport master (
    output PADDR, PWRITE, PDATA,
    input  PRDATA, PSEL_HIT
  );

  modport slave (
    input  PADDR, PWRITE, PDATA,
    output PRDATA, PSEL_HIT
  );
endinterface

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter.
// Stores to TXDATA push bytes into a TX FIFO; a serializer drains the FIFO onto
// TXD with a bit period of DIV+1 clocks. Loads are side-effect free.
//   CLK    : system clock
//   RESET  : synchronous, active-high reset
//   bus    : memory window (PADDR/PWRITE/PDATA in, PRDATA/PSEL_HIT out)
//   TXD    : registered serial output, idle high
//   TX_IRQ : registered, high when the FIFO is empty and the serializer idle
// Register window (offset from BASE_ADDR): 0x00 TXDATA, 0x08 STATUS, 0x10 DIV.
//
// state | meaning
// IDLE  | line high, waiting for a FIFO entry
// START | driving the start bit (low)
// DATA  | driving shift[0], 8 bits LSB first
// STOP  | driving the stop bit (high), then chain or go idle
module uart_tx_mmio #(
  parameter logic [63:0] BASE_ADDR   = 64'h0000_0000_1000_0000,
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd867
) (
  input  logic          CLK,
  input  logic          RESET,
  uart_tx_mmio_if.slave bus,
  output logic          TXD,
  output logic          TX_IRQ
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  // Address decode. Comparing the offset instead of BASE_ADDR+0x18 avoids
  // wrap-around when the window sits at the top of the address space.
  logic [63:0] offset;
  logic        hit;
  logic        wr_txdata, wr_status, wr_div;

  assign offset    = bus.PADDR - BASE_ADDR;
  assign hit       = (bus.PADDR >= BASE_ADDR) && (offset < 64'h18);
  assign wr_txdata = bus.PWRITE && hit && (offset == 64'h00);
  assign wr_status = bus.PWRITE && hit && (offset == 64'h08);
  assign wr_div    = bus.PWRITE && hit && (offset == 64'h10);

  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          overflow;
  logic          full, empty, pop, push_ok;
  logic [15:0]   div_reg;

  state_t      state, state_n;
  logic [15:0] baud_cnt, baud_n;
  logic [2:0]  bit_cnt, bit_n;
  logic [7:0]  shift_q, shift_n;
  logic [15:0] div_q, div_q_n;
  logic        txd_n;

  assign full    = (count == CW'(FIFO_DEPTH));
  assign empty   = (count == '0);
  // A pop on the same edge frees the slot, so a push into a full FIFO still lands.
  assign push_ok = wr_txdata && (!full || pop);

  always_ff @(posedge CLK) begin
    if (push_ok) fifo_mem[wr_ptr] <= bus.PDATA[7:0];
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      div_reg  <= DEFAULT_DIV;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (wr_txdata && full && !pop)     overflow <= 1'b1;
      else if (wr_status && bus.PDATA[3]) overflow <= 1'b0;
      if (wr_div) div_reg <= bus.PDATA[15:0];
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift_q  <= '0;
      div_q    <= '0;
      TXD      <= 1'b1;
      TX_IRQ   <= 1'b1;
    end else begin
      state    <= state_n;
      baud_cnt <= baud_n;
      bit_cnt  <= bit_n;
      shift_q  <= shift_n;
      div_q    <= div_q_n;
      TXD      <= txd_n;
      TX_IRQ   <= empty && (state == IDLE);
    end
  end

  always_comb begin
    state_n = state;
    baud_n  = baud_cnt;
    bit_n   = bit_cnt;
    shift_n = shift_q;
    div_q_n = div_q;
    pop     = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          shift_n = fifo_mem[rd_ptr];
          div_q_n = div_reg;
          baud_n  = div_reg;
          state_n = START;
        end
      end
      START: begin
        if (baud_cnt == 16'd0) begin
          baud_n  = div_q;
          bit_n   = 3'd0;
          state_n = DATA;
        end else begin
          baud_n = baud_cnt - 16'd1;
        end
      end
      DATA: begin
        if (baud_cnt == 16'd0) begin
          shift_n = {1'b0, shift_q[7:1]};
          baud_n  = div_q;
          if (bit_cnt == 3'd7) state_n = STOP;
          else                 bit_n   = bit_cnt + 3'd1;
        end else begin
          baud_n = baud_cnt - 16'd1;
        end
      end
      STOP: begin
        if (baud_cnt == 16'd0) begin
          if (!empty) begin
            pop     = 1'b1;
            shift_n = fifo_mem[rd_ptr];
            div_q_n = div_reg;
            baud_n  = div_reg;
            state_n = START;
          end else begin
            state_n = IDLE;
          end
        end else begin
          baud_n = baud_cnt - 16'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // TXD is registered from the next state so the line changes on the same edge
  // the state does.
  always_comb begin
    case (state_n)
      START:   txd_n = 1'b0;
      DATA:    txd_n = shift_n[0];
      default: txd_n = 1'b1;
    endcase
  end

  always_comb begin
    bus.PRDATA = 64'd0;
    if (hit) begin
      case (offset)
        64'h08:  bus.PRDATA = {48'd0, 8'(count), 4'd0, overflow, empty, full, (state != IDLE)};
        64'h10:  bus.PRDATA = {48'd0, div_reg};
        default: bus.PRDATA = 64'd0;
      endcase
    end
  end

  assign bus.PSEL_HIT = hit;

  logic unused_ok;
  assign unused_ok = ^{bus.PDATA[63:16], bus.PDATA[14:8], bus.PDATA[7:4], bus.PDATA[2:0]};

endmodule
